// File: rtl/demux_reg4_pkg.sv
// demux_reg4_pkg: channel encodings and default data width for demux_reg4
package demux_reg4_pkg;
  localparam int WIDTH_DEF = 8;
  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;
endpackage

// File: rtl/demux_reg4_slot.sv
// demux_slot: one holding register with data-present flag
// ports: clk_i, rst_i (async, active-high), load_i (write d_i), ack_i (consume),
//        q_o (held data), valid_o (data present)
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             ack_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             valid_o
);
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  // a load wins over a same-cycle ack, keeping one write per cycle throughput
  always_comb begin
    data_d  = load_i ? d_i : data_q;
    valid_d = load_i | (valid_q & ~ack_i);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
  assign q_o     = data_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/demux_reg4.sv
// demux_reg4: 1-to-4 demultiplexer into per-channel holding registers with overflow flag
// ports: clk_i, rst_i (async, active-high), in_i/sel_i/in_valid_i (write), in_ready_o,
//        out_a_o..out_d_o, valid_o[3:0], ack_i[3:0], overflow_o (sticky), ovf_clr_i
module demux_reg4 import demux_reg4_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] in_i,
  input  logic [1:0]       sel_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_a_o,
  output logic [WIDTH-1:0] out_b_o,
  output logic [WIDTH-1:0] out_c_o,
  output logic [WIDTH-1:0] out_d_o,
  output logic [3:0]       valid_o,
  input  logic [3:0]       ack_i,
  output logic             overflow_o,
  input  logic             ovf_clr_i
);
  logic [WIDTH-1:0] data [4];
  logic [3:0]       load;
  logic             accept, ovf_q, ovf_d;
  assign in_ready_o = !valid_o[sel_i] || ack_i[sel_i];
  assign accept     = in_valid_i && in_ready_o;
  assign load = {accept && sel_i == CH_D, accept && sel_i == CH_C,
                 accept && sel_i == CH_B, accept && sel_i == CH_A};
  for (genvar i = 0; i < 4; i++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (load[i]),
      .ack_i  (ack_i[i]),
      .d_i    (in_i),
      .q_o    (data[i]),
      .valid_o(valid_o[i])
    );
  end
  // a new rejection outranks a clear so no overflow event is lost
  always_comb ovf_d = (in_valid_i && !in_ready_o) ? 1'b1 : ovf_clr_i ? 1'b0 : ovf_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end
  assign overflow_o = ovf_q;
  assign out_a_o    = data[0];
  assign out_b_o    = data[1];
  assign out_c_o    = data[2];
  assign out_d_o    = data[3];
endmodule
